// File: rtl/centroid_tracker_if.sv
// Bundles the accumulator-facing inputs and the tracker outputs of
// centroid_tracker.
//   frame_addr   : current pixel address, same bus the accumulator uses
//   accu_cnt     : accumulator pixel count for the last frame
//   accu_avg_x/y : accumulator mean position (all-ones = no target)
//   frame_tick   : one-cycle pulse when a frame result is sampled
//   state        : 00 SEARCH, 01 ACQUIRE, 10 TRACK, 11 LOST
//   target_valid : high in TRACK or LOST
//   track_x/y    : smoothed target position
//   steer        : 00 STOP, 01 LEFT, 10 RIGHT, 11 FORWARD
// The slave modport is the tracker; the master modport is whoever drives the
// accumulator results and consumes the steering command.
interface centroid_tracker_if;
   logic [16:0] frame_addr;
   logic [16:0] accu_cnt;
   logic [8:0]  accu_avg_x;
   logic [7:0]  accu_avg_y;
   logic        frame_tick;
   logic [1:0]  state;
   logic        target_valid;
   logic [8:0]  track_x;
   logic [7:0]  track_y;
   logic [1:0]  steer;

   modport slave (
      input  frame_addr, accu_cnt, accu_avg_x, accu_avg_y,
      output frame_tick, state, target_valid, track_x, track_y, steer
   );

   modport master (
      output frame_addr, accu_cnt, accu_avg_x, accu_avg_y,
      input  frame_tick, state, target_valid, track_x, track_y, steer
   );
endinterface

// File: rtl/centroid_tracker.sv
// Centroid tracker. It sits downstream of the per-frame pixel accumulator and
// samples one result per frame. A hit/miss-debounced SEARCH/ACQUIRE/TRACK/LOST
// state machine follows the target. The position is smoothed with a
// shift-based IIR filter, and a registered steering command is produced.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : centroid_tracker_if.slave (accumulator inputs, tracker outputs)
//
// state   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | no target; waiting for the first hit frame
// ACQUIRE | counting consecutive hits before committing to a target
// TRACK   | target locked; each hit refines track_x/y through the IIR
// LOST    | target missing; track held while misses are counted
module centroid_tracker #(
   parameter logic [8:0]  VGA_WIDTH      = 9'd320,
   parameter logic [7:0]  VGA_HEIGHT     = 8'd240,
   parameter logic [16:0] MIN_CNT        = 17'd200,
   parameter logic [8:0]  CENTER_BAND    = 9'd20,
   parameter int          ACQUIRE_FRAMES = 3,
   parameter int          LOST_FRAMES    = 5,
   parameter int          SMOOTH_SHIFT   = 2
) (
   input  logic            clk,
   input  logic            rst,
   centroid_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'b00,
      ST_ACQUIRE = 2'b01,
      ST_TRACK   = 2'b10,
      ST_LOST    = 2'b11
   } state_t;

   localparam logic [1:0] STEER_STOP  = 2'b00;
   localparam logic [1:0] STEER_LEFT  = 2'b01;
   localparam logic [1:0] STEER_RIGHT = 2'b10;
   localparam logic [1:0] STEER_FWD   = 2'b11;

   localparam int          FRAME_PIX = int'(VGA_WIDTH) * int'(VGA_HEIGHT);
   localparam logic [16:0] LAST_ADDR = 17'(FRAME_PIX - 1);
   localparam logic [8:0]  HALF_W    = VGA_WIDTH >> 1;
   localparam logic [7:0]  HALF_H    = VGA_HEIGHT >> 1;
   localparam logic [8:0]  LEFT_LIM  = HALF_W - CENTER_BAND;
   localparam logic [8:0]  RIGHT_LIM = HALF_W + CENTER_BAND;
   localparam logic [7:0]  ACQ_N     = 8'(ACQUIRE_FRAMES);
   localparam logic [7:0]  LOST_N    = 8'(LOST_FRAMES);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        frame_tick_q, frame_tick_d;
   logic [7:0]  hit_cnt_q, hit_cnt_d;
   logic [7:0]  miss_cnt_q, miss_cnt_d;
   logic [8:0]  track_x_q, track_x_d;
   logic [7:0]  track_y_q, track_y_d;
   logic [1:0]  steer_q, steer_d;

   logic        is_last;
   logic        hit;
   logic signed [9:0] dx, step_x;
   logic signed [8:0] dy, step_y;
   logic [8:0]  iir_x;
   logic [7:0]  iir_y;

   assign is_last = (bus.frame_addr == LAST_ADDR);
   assign hit     = (bus.accu_cnt >= MIN_CNT) && (bus.accu_avg_x != 9'h1FF) &&
                    (bus.accu_avg_y != 8'hFF);

   // The arithmetic shift floors the step, so the result stays between the
   // old track and the new sample and the truncated add cannot wrap.
   assign dx     = signed'({1'b0, bus.accu_avg_x}) - signed'({1'b0, track_x_q});
   assign dy     = signed'({1'b0, bus.accu_avg_y}) - signed'({1'b0, track_y_q});
   assign step_x = dx >>> SMOOTH_SHIFT;
   assign step_y = dy >>> SMOOTH_SHIFT;
   assign iir_x  = track_x_q + step_x[8:0];
   assign iir_y  = track_y_q + step_y[7:0];

   always_comb begin
      state_d    = state_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      track_x_d  = track_x_q;
      track_y_d  = track_y_q;
      last_d     = is_last;
      // Tick on the falling edge of the last-pixel flag; the accumulator
      // results are stable by then, and a held LAST address ticks only once.
      frame_tick_d = last_q && !is_last;

      if (frame_tick_q) begin
         unique case (state_q)
            ST_SEARCH: begin
               if (hit) begin
                  state_d   = ST_ACQUIRE;
                  hit_cnt_d = 8'd1;
               end
            end
            ST_ACQUIRE: begin
               if (hit) begin
                  if (hit_cnt_q + 8'd1 >= ACQ_N) begin
                     state_d   = ST_TRACK;
                     track_x_d = bus.accu_avg_x;
                     track_y_d = bus.accu_avg_y;
                  end else begin
                     hit_cnt_d = hit_cnt_q + 8'd1;
                  end
               end else begin
                  state_d   = ST_SEARCH;
                  hit_cnt_d = 8'd0;
               end
            end
            ST_TRACK: begin
               if (hit) begin
                  track_x_d = iir_x;
                  track_y_d = iir_y;
               end else begin
                  state_d    = ST_LOST;
                  miss_cnt_d = 8'd1;
               end
            end
            ST_LOST: begin
               if (hit) begin
                  state_d    = ST_TRACK;
                  miss_cnt_d = 8'd0;
                  track_x_d  = iir_x;
                  track_y_d  = iir_y;
               end else if (miss_cnt_q + 8'd1 >= LOST_N) begin
                  state_d    = ST_SEARCH;
                  miss_cnt_d = 8'd0;
                  hit_cnt_d  = 8'd0;
               end else begin
                  miss_cnt_d = miss_cnt_q + 8'd1;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end

      // Steering follows the registered state/track, one cycle behind.
      steer_d = STEER_STOP;
      if (state_q == ST_TRACK || state_q == ST_LOST) begin
         if (track_x_q < LEFT_LIM)       steer_d = STEER_LEFT;
         else if (track_x_q > RIGHT_LIM) steer_d = STEER_RIGHT;
         else                            steer_d = STEER_FWD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_SEARCH;
         last_q       <= 1'b0;
         frame_tick_q <= 1'b0;
         hit_cnt_q    <= 8'd0;
         miss_cnt_q   <= 8'd0;
         track_x_q    <= HALF_W;
         track_y_q    <= HALF_H;
         steer_q      <= STEER_STOP;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         frame_tick_q <= frame_tick_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         track_x_q    <= track_x_d;
         track_y_q    <= track_y_d;
         steer_q      <= steer_d;
      end
   end

   assign bus.frame_tick   = frame_tick_q;
   assign bus.state        = state_q;
   assign bus.target_valid = (state_q == ST_TRACK) || (state_q == ST_LOST);
   assign bus.track_x      = track_x_q;
   assign bus.track_y      = track_y_q;
   assign bus.steer        = steer_q;

endmodule
